// File: rtl/sw_loader_pkg.sv
// Shared types and constants for the switch/button word loader.
package sw_loader_pkg;
  typedef enum logic {
    COLLECT,
    PRESENT
  } state_t;

  localparam int unsigned LANES = 4;
  localparam int unsigned DEBOUNCE_DEF = 20;
endpackage

// File: rtl/sw_word_loader_debounce.sv
// Button front end: 2-flop sync, stability counter, rising-edge pulse.
module btn_debounce
  import sw_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise_pulse
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= raw_in;
      r_sync1   <= r_sync0;
      r_level_d <= r_level;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
        // Accept only after the count has sat at the limit for an edge.
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_level & ~r_level_d;
endmodule

// File: rtl/sw_word_loader.sv
// Assembles four switch bytes (LSB first) into a word on a valid/ready port.
module sw_word_loader
  import sw_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        SW,
  input  logic              BTN,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [1:0]        byte_idx,
  output logic              wrapped
);
  logic              w_level;
  logic              w_press;
  logic [7:0]        r_sw0;
  logic [7:0]        r_sw1;
  state_t            r_state;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_idx;
  logic              r_wrapped;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (BTN),
    .level     (w_level),
    .rise_pulse(w_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw0 <= '0;
      r_sw1 <= '0;
    end else begin
      r_sw0 <= SW;
      r_sw1 <= r_sw0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_idx     <= '0;
      r_wrapped <= 1'b0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_press) begin
            r_data[8*r_idx +: 8] <= r_sw1;
            if (r_idx == 2'(LANES - 1)) begin
              r_idx   <= '0;
              r_valid <= 1'b1;
              r_state <= PRESENT;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        PRESENT: begin
          // Presses here are dropped, not queued.
          if (r_valid && wr_ready) begin
            r_valid <= 1'b0;
            r_addr  <= r_addr + ADDR_W'(1);
            if (&r_addr) r_wrapped <= 1'b1;
            r_state <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign wr_valid = r_valid;
  assign wr_addr  = r_addr;
  assign wr_data  = r_data;
  assign byte_idx = r_idx;
  assign wrapped  = r_wrapped;
endmodule
